// File: rtl/vote_collector.sv
// vote_collector: gathers five single-bit votes into a round, reports the
// minority result (at most two "yes" votes), and hands the completed round to
// a consumer with a valid/ready handshake. A round that goes idle for
// TIMEOUT_CYCLES cycles is discarded with a one-cycle timeout pulse, and an
// abort discards it silently. The rounds counter tracks consumed rounds.
module vote_collector #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       vote_in,
  input  logic       vote_valid,
  output logic       vote_ready,
  input  logic       abort,
  output logic [4:0] votes,
  output logic [2:0] count,
  output logic       result,
  output logic       result_valid,
  input  logic       result_ready,
  output logic       timeout,
  output logic [7:0] rounds
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DONE    = 1'b1;

  // Nine bits so the increment of a full 8-bit timer cannot wrap before the
  // comparison against the limit.
  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CYCLES);

  logic [0:0] state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [4:0] votes_q, votes_d;
  logic [7:0] timer_q, timer_d;
  logic       timeout_q, timeout_d;
  logic [7:0] rounds_q, rounds_d;

  logic       accept;
  logic [8:0] timer_inc;
  logic [2:0] ones;

  // Handshake: a vote is taken only while collecting and not aborting; the
  // reset term keeps vote_ready low for the whole time reset is asserted.
  assign vote_ready = reset_L & (state_q == COLLECT) & ~abort;
  assign accept     = vote_valid & vote_ready;
  assign timer_inc  = {1'b0, timer_q} + 9'd1;

  // Minority result: popcount of the registered vote vector, 1 when <= 2.
  assign ones   = {2'b00, votes_q[4]} + {2'b00, votes_q[3]} + {2'b00, votes_q[2]}
                + {2'b00, votes_q[1]} + {2'b00, votes_q[0]};
  assign result = (ones <= 3'd2);

  assign votes        = votes_q;
  assign count        = count_q;
  assign result_valid = (state_q == DONE);
  assign timeout      = timeout_q;
  assign rounds       = rounds_q;

  // Next-state logic: abort beats the idle timer, an accepted vote beats it too.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    votes_d   = votes_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    rounds_d  = rounds_q;

    case (state_q)
      COLLECT: begin
        if (abort) begin
          count_d = 3'd0;
          votes_d = 5'b00000;
          timer_d = 8'd0;
        end else if (accept) begin
          // First vote lands in bit 4, the fifth in bit 0.
          votes_d[3'd4 - count_q] = vote_in;
          count_d = count_q + 3'd1;
          timer_d = 8'd0;
          if (count_q == 3'd4) begin
            state_d = DONE;
          end
        end else if (count_q == 3'd0) begin
          timer_d = 8'd0;
        end else if (timer_inc == TIMEOUT_LIM) begin
          count_d   = 3'd0;
          votes_d   = 5'b00000;
          timer_d   = 8'd0;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_inc[7:0];
        end
      end
      DONE: begin
        // Result held until consumed; abort and the idle timer are ignored.
        if (result_ready) begin
          state_d  = COLLECT;
          count_d  = 3'd0;
          votes_d  = 5'b00000;
          rounds_d = rounds_q + 8'd1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= COLLECT;
      count_q   <= 3'd0;
      votes_q   <= 5'b00000;
      timer_q   <= 8'd0;
      timeout_q <= 1'b0;
      rounds_q  <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from
      // values computed in the same cycle.
      state_q   <= state_d;
      count_q   <= count_d;
      votes_q   <= votes_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      rounds_q  <= rounds_d;
    end
  end

endmodule

// File: tb/tb_vote_collector.sv
// Self-checking bench for vote_collector: directed scenarios followed by
// randomized traffic, all compared against a queue-based round model.
module tb_vote_collector;

  localparam int T = 4;

  logic       clock;
  logic       reset_L;
  logic       vote_in;
  logic       vote_valid;
  logic       vote_ready;
  logic       abort;
  logic [4:0] votes;
  logic [2:0] count;
  logic       result;
  logic       result_valid;
  logic       result_ready;
  logic       timeout;
  logic [7:0] rounds;

  int checks;
  int failures;

  // Reference model: the votes of the round in progress, idle cycle count,
  // whether a finished round awaits the consumer, consumed rounds, pulse.
  bit m_q[$];
  int m_idle;
  bit m_done;
  int m_rounds;
  bit m_tout;

  vote_collector #(.TIMEOUT_CYCLES(T)) dut (
    .clock        (clock),
    .reset_L      (reset_L),
    .vote_in      (vote_in),
    .vote_valid   (vote_valid),
    .vote_ready   (vote_ready),
    .abort        (abort),
    .votes        (votes),
    .count        (count),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .timeout      (timeout),
    .rounds       (rounds)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model_votes();
    logic [4:0] v;
    v = 5'b00000;
    for (int i = 0; i < m_q.size(); i++) v[4 - i] = m_q[i];
    return v;
  endfunction

  function automatic logic model_result();
    int ones;
    ones = 0;
    foreach (m_q[i]) ones += int'(m_q[i]);
    return (ones <= 2);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_idle   = 0;
    m_done   = 1'b0;
    m_rounds = 0;
    m_tout   = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit vi, input bit ab, input bit rr);
    m_tout = 1'b0;
    if (m_done) begin
      if (rr) begin
        m_done   = 1'b0;
        m_q.delete();
        m_rounds = (m_rounds + 1) % 256;
      end
    end else if (ab) begin
      m_q.delete();
      m_idle = 0;
    end else if (v) begin
      m_q.push_back(vi);
      m_idle = 0;
      if (m_q.size() == 5) m_done = 1'b1;
    end else if (m_q.size() == 0) begin
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == T) begin
        m_q.delete();
        m_idle = 0;
        m_tout = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check("votes", {3'b000, votes}, {3'b000, model_votes()});
    check("count", {5'b00000, count}, 8'(m_q.size()));
    check("result_valid", {7'd0, result_valid}, {7'd0, m_done});
    check("timeout", {7'd0, timeout}, {7'd0, m_tout});
    check("rounds", rounds, 8'(m_rounds));
    if (m_done) check("result", {7'd0, result}, {7'd0, model_result()});
  endtask

  // One clock cycle: drive inputs, check vote_ready, advance model and DUT.
  task automatic cycle(input bit v, input bit vi, input bit ab, input bit rr);
    vote_valid   = v;
    vote_in      = vi;
    abort        = ab;
    result_ready = rr;
    #1;
    check("vote_ready", {7'd0, vote_ready}, {7'd0, (!m_done && !ab)});
    model_step(v, vi, ab, rr);
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic reset_zero_checks(input string tag);
    check({tag, "_count"}, {5'b00000, count}, 8'd0);
    check({tag, "_votes"}, {3'b000, votes}, 8'd0);
    check({tag, "_rounds"}, rounds, 8'd0);
    check({tag, "_result_valid"}, {7'd0, result_valid}, 8'd0);
    check({tag, "_timeout"}, {7'd0, timeout}, 8'd0);
    check({tag, "_vote_ready"}, {7'd0, vote_ready}, 8'd0);
  endtask

  initial begin
    logic [4:0] vec;
    checks   = 0;
    failures = 0;
    model_reset();

    // Power-on reset, checked before any clock edge; vote_valid held high.
    reset_L      = 1'b0;
    vote_valid   = 1'b1;
    vote_in      = 1'b1;
    abort        = 1'b0;
    result_ready = 1'b0;
    #3;
    reset_zero_checks("por");
    @(posedge clock);
    #1;
    check("por_edge_count", {5'b00000, count}, 8'd0);
    // Release away from the edge; the pending vote is taken on the next edge.
    @(negedge clock);
    reset_L = 1'b1;
    model_step(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    check_outputs();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);  // abort to start clean

    // Votes 0,0,1,0,1 back to back.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("r035_votes", {3'b000, votes}, 8'h05);
    check("r035_result", {7'd0, result}, 8'd1);
    check("r035_valid", {7'd0, result_valid}, 8'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Votes 1,1,0,1,0 held for three cycles with abort/vote noise, then taken.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, i == 1, 1'b0);
      check("r036_votes", {3'b000, votes}, 8'h1a);
      check("r036_result", {7'd0, result}, 8'd0);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("r036_rounds", rounds, 8'd2);

    // Two votes then idle: timeout after T idle cycles.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < T; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("r037_timeout", {7'd0, timeout}, 8'd1);
    check("r037_count", {5'b00000, count}, 8'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("r037_pulse_end", {7'd0, timeout}, 8'd0);

    // Vote arriving on the would-be expiry edge wins.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < T - 1; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("r029_count", {5'b00000, count}, 8'd3);
    check("r029_timeout", {7'd0, timeout}, 8'd0);

    // Abort coinciding with expiry: abort only, no pulse.
    for (int i = 0; i < T - 1; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("r026_timeout", {7'd0, timeout}, 8'd0);

    // Three votes then abort with a vote offered in the same cycle.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check("r038_count", {5'b00000, count}, 8'd0);
    check("r038_votes", {3'b000, votes}, 8'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("r038_timeout", {7'd0, timeout}, 8'd0);

    // Reset pulsed mid-round with count = 3, checked without a clock edge.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    vote_valid = 1'b0;
    #2;
    reset_L = 1'b0;
    #1;
    reset_zero_checks("r039");
    model_reset();
    @(negedge clock);
    reset_L = 1'b1;
    @(posedge clock);
    #1;
    check_outputs();

    // 256 rounds covering all 32 vectors, with random gaps and consumer stalls.
    for (int r = 0; r < 256; r++) begin
      vec = 5'(r % 32);
      for (int b = 4; b >= 0; b--) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, vec[b], 1'b0, 1'b0);
      end
      check("r040_vec", {3'b000, votes}, {3'b000, vec});
      for (int g = 0; g < int'($urandom_range(0, 2)); g++)
        cycle(1'b0, 1'b0, ($urandom % 2) == 1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
    end
    check("r040_wrap", rounds, 8'd0);

    // Fully random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 2) == 1, ($urandom % 2) == 1, ($urandom % 16) == 0,
            ($urandom % 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
